cb_config_loader: RTL and testbench
===================================

Name: cb_config_loader

Overview:
- Serial configuration loader for `data_connection_block`.
- Accepts the configuration bitstream one bit per transfer on a valid/ready handshake and assembles it in a shadow register.
- On frame completion, atomically commits the frame to the parallel `c` bus and pulses `cset`.
- Sits between the fabric bitstream chain and each connection block; `chain_out` allows daisy-chaining loaders.

Parameters:
- W, 16, routing tracks per direction (north/south).
- WW, 4, word width of data ports.
- DATAIN, 4, data input words taken from the tracks.
- DATAOUT, 3, data output words driven onto the tracks.
- CFG_BITS, derived (not overridable) = clog2(2*W/WW)*DATAIN*WW + clog2(DATAOUT+1)*W*2. This is 112 at defaults.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; begins a new frame.
- cfg_in  in  1  serial configuration bit.
- cfg_valid  in  1  cfg_in is valid.
- cfg_ready  out  1  loader accepts a bit this cycle.
- c  out  CFG_BITS  committed configuration to the connection block.
- cset  out  1  one-cycle commit strobe, coincident with the new c value.
- busy  out  1  frame in progress (SHIFT or COMMIT).
- done  out  1  last frame committed; level.
- err  out  1  parity error, sticky until next cfg_start.
- chain_out  out  1  registered bit shifted out of shadow[0] on each transfer.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; count = 0; shadow = 0.
  - c = 0, which gives default pass-through routing: north_out=south_in, south_out=north_in.
  - cset, done, err, chain_out = 0.
  - Reset mid-frame discards the partial frame.
- States: IDLE, SHIFT, COMMIT, DONE.
- cfg_ready = (state==SHIFT) & ~cfg_start (combinational).
- Transfer: occurs only when cfg_valid & cfg_ready. On each transfer:
  - shadow <= {cfg_in, shadow[CFG_BITS-1:1]}, i.e. LSB-first, so the first bit received lands in c[0];
  - chain_out <= shadow[0];
  - count increments.
- IDLE or DONE, cfg_start=1 → SHIFT; count=0; done=0; err=0.
- SHIFT:
  - cfg_start=1 restarts the frame: count=0, no bit accepted, c untouched.
  - Transfer with count==CFG_BITS-1 → COMMIT.
- COMMIT (one cycle): at the closing edge, c <= shadow and cset <= 1; → DONE.
- DONE: cset <= 0 at the next edge; done=1 until cfg_start.
- Latency: last bit accepted at edge E; c and cset update at E+1; cset falls at E+2.
- cfg_valid gaps are allowed anywhere in SHIFT; count advances only on transfers.
- c holds its previous value throughout a new frame; there is never a partial update.
- cset is never high for more than one cycle; no cset without a complete frame.

Optional Feature:
- Macro: CB_CFG_PARITY_EN.
- Defined:
  - SHIFT accepts CFG_BITS+1 bits; the last is an even-parity bit.
  - XOR of all CFG_BITS+1 bits == 0 → COMMIT.
  - Otherwise → IDLE with err=1; no commit, c unchanged, done stays 0.
  - The parity bit is not shifted into shadow; chain_out still forwards it.
- Undefined: frame is exactly CFG_BITS bits; err tied 0.

Decomposition:
- Package cb_cfg_pkg:
  - state enum;
  - functions computing SEL_PER_IN = clog2(2*W/WW), SEL_PER_OUT = clog2(DATAOUT+1), and CFG_BITS. These are shared with `data_connection_block` so bit layout cannot diverge.
- One sub-module, cb_cfg_shift_reg: shadow register, chain_out, and parity accumulator with shift enable. FSM and counter stay in the top.

Test Plan:
1. Reset: assert rst low after 50 of 112 bits → c=0, cset=0, cfg_ready=0, busy=0. Then load a full frame → commits normally.
2. Full frame: cfg_start, then 112 back-to-back bits with bit i = (i%3==0) →
   - c[i] matches the pattern;
   - cset high exactly one cycle, the cycle after the last transfer;
   - done=1; connection block routes per decoded selects.
3. Backpressure: cfg_valid random 50% duty, 112 transfers → identical c to scenario 2; count unaffected by idle cycles.
4. Restart: cfg_start at bit 60, then 112 ones →
   - no cset before restart completion;
   - c = all ones;
   - the simultaneous cfg_valid bit in the restart cycle is not accepted.
5. Hold: c loaded with the alternating 0101… pattern, then second frame of zeros started → c keeps the alternating value through all 112 bits and changes to 0 only with cset.
6. CB_CFG_PARITY_EN:
   - 113-bit frame with bad parity → err=1, c unchanged, no cset;
   - correct parity → commit, err=0.

Source files
------------

// File: rtl/cb_cfg_pkg.sv
// cb_cfg_pkg: shared definitions for the connection-block configuration loader.
// Holds the loader FSM state type and the functions that size the configuration
// word. data_connection_block uses the same functions, so the select-field layout
// is defined in one place.
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit,
        StDone
    } cfg_state_e;

    // Select bits per data input word: picks one of 2*W/WW track words.
    function automatic int unsigned sel_per_in(input int unsigned w, input int unsigned ww);
        return $clog2(2 * w / ww);
    endfunction

    // Select bits per track: picks one of DATAOUT output words, or pass-through.
    function automatic int unsigned sel_per_out(input int unsigned dataout);
        return $clog2(dataout + 1);
    endfunction

    function automatic int unsigned cfg_bits(input int unsigned w, input int unsigned ww,
                                             input int unsigned datain,
                                             input int unsigned dataout);
        return sel_per_in(w, ww) * datain * ww + sel_per_out(dataout) * w * 2;
    endfunction

endpackage

// File: rtl/cb_cfg_shift_reg.sv
// cb_cfg_shift_reg: shadow register for the configuration loader.
// Shifts one bit in at the MSB per enabled cycle (LSB-first frame order), registers
// the bit leaving shadow[0] onto chain_out, and, with CB_CFG_PARITY_EN defined,
// keeps a running XOR of the received bits.
//   clk, rst       clock, asynchronous active-low reset
//   shift_en       accept bit_in this cycle
//   clr            (parity build) clear the parity accumulator at frame start
//   par_bit        (parity build) bit_in is the parity bit: forwarded, not stored
//   par_acc        (parity build) XOR of all bits accepted since clr
//   bit_in         serial data
//   shadow         assembled frame
//   chain_out      registered daisy-chain output
module cb_cfg_shift_reg #(
    parameter int unsigned N = 112
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
`ifdef CB_CFG_PARITY_EN
    input  logic         clr,
    input  logic         par_bit,
    output logic         par_acc,
`endif
    input  logic         bit_in,
    output logic [N-1:0] shadow,
    output logic         chain_out
);

    logic [N-1:0] shadow_q;
    logic         chain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            chain_q  <= 1'b0;
        end else if (shift_en) begin
`ifdef CB_CFG_PARITY_EN
            if (par_bit) begin
                // Parity bit passes straight down the chain; the shadow keeps the data.
                chain_q <= bit_in;
            end else begin
                chain_q  <= shadow_q[0];
                shadow_q <= {bit_in, shadow_q[N-1:1]};
            end
`else
            chain_q  <= shadow_q[0];
            shadow_q <= {bit_in, shadow_q[N-1:1]};
`endif
        end
    end

`ifdef CB_CFG_PARITY_EN
    logic acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 1'b0;
        end else if (clr) begin
            acc_q <= 1'b0;
        end else if (shift_en) begin
            acc_q <= acc_q ^ bit_in;
        end
    end

    assign par_acc = acc_q;
`endif

    assign shadow    = shadow_q;
    assign chain_out = chain_q;

endmodule

// File: rtl/cb_config_loader.sv
// cb_config_loader: serial configuration loader for data_connection_block.
// Collects a frame one bit per valid/ready transfer (first bit lands in c[0]),
// then commits the whole frame to c in one edge with a single-cycle cset strobe.
// c = 0 after reset selects pass-through routing in the connection block.
// Optional feature macro: CB_CFG_PARITY_EN -- frame carries a trailing even-parity
// bit; a bad frame is dropped and flags err.
//   clk, rst    clock, asynchronous active-low reset
//   cfg_start   one-cycle pulse, begins (or restarts) a frame
//   cfg_in      serial configuration bit
//   cfg_valid   cfg_in is valid
//   cfg_ready   a bit is accepted this cycle when cfg_valid is high
//   c           committed configuration word
//   cset        one-cycle strobe coincident with a new c
//   busy        frame in progress
//   done        last frame committed (level, cleared by cfg_start)
//   err         parity error, sticky until cfg_start (0 without CB_CFG_PARITY_EN)
//   chain_out   bit shifted out of the shadow register, for daisy-chaining
module cb_config_loader
    import cb_cfg_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned WW      = 4,
    parameter int unsigned DATAIN  = 4,
    parameter int unsigned DATAOUT = 3,
    localparam int unsigned CFG_BITS = cfg_bits(W, WW, DATAIN, DATAOUT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_in,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] c,
    output logic                cset,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                chain_out
);

`ifdef CB_CFG_PARITY_EN
    localparam int unsigned FrameLen = CFG_BITS + 1;
`else
    localparam int unsigned FrameLen = CFG_BITS;
`endif
    localparam int unsigned CntW = $clog2(FrameLen + 1);

    cfg_state_e          state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [CFG_BITS-1:0] c_q, c_d;
    logic                cset_q, cset_d;
    logic                done_q, done_d;
    logic [CFG_BITS-1:0] shadow;
    logic                xfer;
    logic                last_bit;

    assign cfg_ready = (state_q == StShift) & ~cfg_start;
    assign xfer      = cfg_valid & cfg_ready;
    assign last_bit  = (count_q == CntW'(FrameLen - 1));

`ifdef CB_CFG_PARITY_EN
    logic err_q, err_d;
    logic par_acc;

    cb_cfg_shift_reg #(
        .N (CFG_BITS)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (xfer),
        .clr       (cfg_start & (state_q != StCommit)),
        .par_bit   (count_q == CntW'(CFG_BITS)),
        .par_acc   (par_acc),
        .bit_in    (cfg_in),
        .shadow    (shadow),
        .chain_out (chain_out)
    );
`else
    cb_cfg_shift_reg #(
        .N (CFG_BITS)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (xfer),
        .bit_in    (cfg_in),
        .shadow    (shadow),
        .chain_out (chain_out)
    );
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        c_d     = c_q;
        cset_d  = 1'b0;
        done_d  = done_q;
`ifdef CB_CFG_PARITY_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (cfg_start) begin
                    state_d = StShift;
                    count_d = '0;
                    done_d  = 1'b0;
`ifdef CB_CFG_PARITY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StShift: begin
                if (cfg_start) begin
                    count_d = '0;
                end else if (xfer) begin
                    count_d = count_q + CntW'(1);
                    if (last_bit) begin
`ifdef CB_CFG_PARITY_EN
                        // Accumulator holds XOR of the data bits; total XOR is zero
                        // exactly when the parity bit equals it.
                        if (par_acc == cfg_in) begin
                            state_d = StCommit;
                        end else begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
`else
                        state_d = StCommit;
`endif
                    end
                end
            end
            StCommit: begin
                c_d     = shadow;
                cset_d  = 1'b1;
                done_d  = 1'b1;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            c_q     <= '0;
            cset_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            c_q     <= c_d;
            cset_q  <= cset_d;
            done_q  <= done_d;
        end
    end

`ifdef CB_CFG_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign c    = c_q;
    assign cset = cset_q;
    assign done = done_q;
    assign busy = (state_q == StShift) | (state_q == StCommit);

endmodule

// File: tb/tb_cb_config_loader.sv
// Self-checking bench for cb_config_loader. A queue-based reference model tracks
// the frame being received, the shadow contents (as a FIFO) and the committed word.
module tb_cb_config_loader;

    localparam int CFG_BITS = $clog2(2 * 16 / 4) * 4 * 4 + $clog2(3 + 1) * 16 * 2;
`ifdef CB_CFG_PARITY_EN
    localparam int FRAME = CFG_BITS + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = CFG_BITS;
    localparam bit PAR   = 1'b0;
`endif

    typedef logic [CFG_BITS-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_start = 1'b0;
    logic cfg_in = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    vec_t c;
    logic cset, busy, done, err, chain_out;

    always #5 clk = ~clk;

    cb_config_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .c         (c),
        .cset      (cset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .chain_out (chain_out)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model. phase: 0 idle, 1 receiving, 2 frame complete, 3 done.
    int   m_phase;
    bit   m_bits[$];
    bit   m_sh[$];
    vec_t m_c;
    bit   m_cset, m_done, m_err, m_chain;
    int   n_cset;

    task automatic model_reset();
        m_phase = 0;
        m_bits.delete();
        m_sh.delete();
        for (int i = 0; i < CFG_BITS; i++) m_sh.push_back(1'b0);
        m_c = '0;
        m_cset = 0;
        m_done = 0;
        m_err = 0;
        m_chain = 0;
    endtask

    task automatic model_edge(input bit start, input bit valid, input bit b);
        bit par;
        m_cset = 0;
        if (m_phase == 2) begin
            for (int i = 0; i < CFG_BITS; i++) m_c[i] = m_bits[i];
            m_cset = 1;
            m_done = 1;
            m_phase = 3;
        end else if (m_phase == 1) begin
            if (start) begin
                m_bits.delete();
            end else if (valid) begin
                if (m_bits.size() < CFG_BITS) begin
                    m_chain = m_sh.pop_front();
                    m_sh.push_back(b);
                end else begin
                    m_chain = b;
                end
                m_bits.push_back(b);
                if (m_bits.size() == FRAME) begin
                    par = 0;
                    foreach (m_bits[i]) par ^= m_bits[i];
                    if (!PAR || !par) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                        m_err = 1;
                    end
                end
            end
        end else if (start) begin
            m_phase = 1;
            m_bits.delete();
            m_done = 0;
            m_err = 0;
        end
    endtask

    // One clock: drive at +1, check ready mid-cycle, check outputs 1 after the edge.
    task automatic step(input bit start, input bit valid, input bit b);
        cfg_start = start;
        cfg_valid = valid;
        cfg_in    = b;
        #3;
        check("cfg_ready", vec_t'(cfg_ready), vec_t'((m_phase == 1) && !start));
        @(posedge clk);
        model_edge(start, valid, b);
        #1;
        if (cset) n_cset++;
        check("c", c, m_c);
        check("cset", vec_t'(cset), vec_t'(m_cset));
        check("done", vec_t'(done), vec_t'(m_done));
        check("err", vec_t'(err), vec_t'(m_err));
        check("busy", vec_t'(busy), vec_t'(m_phase == 1 || m_phase == 2));
        check("chain_out", vec_t'(chain_out), vec_t'(m_chain));
    endtask

    task automatic do_reset();
        cfg_start = 0;
        cfg_valid = 0;
        cfg_in    = 0;
        rst = 0;
        #2;
        model_reset();
        check("rst_c", c, '0);
        check("rst_cset", vec_t'(cset), '0);
        check("rst_ready", vec_t'(cfg_ready), '0);
        check("rst_busy", vec_t'(busy), '0);
        check("rst_done", vec_t'(done), '0);
        check("rst_chain", vec_t'(chain_out), '0);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pat(input int kind, input int i);
        case (kind)
            0: return (i % 3 == 0);
            1: return 1'($urandom_range(0, 1));
            2: return 1'b1;
            3: return 1'(i % 2);
            default: return 1'b0;
        endcase
    endfunction

    // Deliver nbits accepted bits; with gaps, cfg_valid idles at random.
    task automatic send_bits(input int kind, input int nbits, input bit gaps, input bit bad_par);
        bit acc = 0;
        bit v, b;
        int i = 0;
        while (i < nbits) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            b = pat(kind, i);
            if (PAR && i == CFG_BITS) b = acc ^ bad_par;
            if (!v) b = 1'($urandom_range(0, 1));
            step(0, v, b);
            if (v) begin
                acc ^= b;
                i++;
            end
        end
    endtask

    task automatic frame(input int kind, input bit gaps, input bit bad_par);
        step(1, 0, 0);
        send_bits(kind, FRAME, gaps, bad_par);
        repeat (3) step(0, 0, 0);
    endtask

    initial begin
        int cs0;
        #1;
        do_reset();

        // Reset mid-frame discards the partial frame; next frame commits.
        step(1, 0, 0);
        send_bits(1, 50, 0, 0);
        do_reset();
        frame(1, 0, 0);

        // Back-to-back i%3 pattern, exactly one cset.
        cs0 = n_cset;
        frame(0, 0, 0);
        check("cset_count_b2b", vec_t'(n_cset - cs0), vec_t'(1));

        // Same pattern under random backpressure.
        cs0 = n_cset;
        frame(0, 1, 0);
        check("cset_count_gaps", vec_t'(n_cset - cs0), vec_t'(1));

        // Restart at bit 60 with a simultaneous valid bit, then all ones.
        cs0 = n_cset;
        step(1, 0, 0);
        send_bits(1, 60, 0, 0);
        step(1, 1, 1);
        send_bits(2, FRAME, 0, 0);
        repeat (3) step(0, 0, 0);
        check("cset_count_restart", vec_t'(n_cset - cs0), vec_t'(1));

        // Alternating frame, then zeros: c holds until the commit.
        frame(3, 0, 0);
        frame(4, 1, 0);

        // Random frames with occasional restarts.
        repeat (4) begin
            step(1, 0, 0);
            if ($urandom_range(0, 1)) begin
                send_bits(1, int'($urandom_range(1, FRAME - 1)), 1, 0);
                step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            send_bits(1, FRAME, 1, 0);
            repeat (3) step(0, 0, 0);
        end

`ifdef CB_CFG_PARITY_EN
        cs0 = n_cset;
        frame(1, 0, 1);
        check("cset_count_badpar", vec_t'(n_cset - cs0), vec_t'(0));
        frame(1, 1, 0);
        check("cset_count_goodpar", vec_t'(n_cset - cs0), vec_t'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
